// File: rtl/rom_download_sequencer_if.sv
// ---------------------------------------------------------------------------
// rom_download_sequencer_if
//   Bundles the data_io download stream and the two SDRAM toggle-handshake
//   write ports that the ROM download sequencer sits between.
//
//   master : the sequencer (consumes ioctl_*, issues port writes)
//   slave  : the environment (data_io + sdram controller side)
//
//   ioctl_downl/ioctl_wr/ioctl_addr/ioctl_dout : download stream from data_io
//   ioctl_wait                                 : back-pressure to data_io
//   portN_req/portN_ack                        : toggle request / toggle ack
//   portN_a/portN_ds/portN_d/portN_we          : word address, byte selects,
//                                                write data, write enable
// ---------------------------------------------------------------------------
interface rom_download_sequencer_if;
    logic        ioctl_downl;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port1_we;

    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        port2_we;

    modport master (
        input  ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout,
        input  port1_ack, port2_ack,
        output ioctl_wait,
        output port1_req, port1_a, port1_ds, port1_d, port1_we,
        output port2_req, port2_a, port2_ds, port2_d, port2_we
    );

    modport slave (
        output ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout,
        output port1_ack, port2_ack,
        input  ioctl_wait,
        input  port1_req, port1_a, port1_ds, port1_d, port1_we,
        input  port2_req, port2_a, port2_ds, port2_d, port2_we
    );
endinterface

// File: rtl/rom_download_sequencer.sv
// ---------------------------------------------------------------------------
// rom_download_sequencer
//   Streams ROM bytes arriving from data_io into SDRAM. Every byte goes to
//   port1 (CPU image); bytes at or above BG_BASE additionally go to port2
//   (merged background/sprite graphics) with the address rebased. data_io is
//   held off through ioctl_wait until every issued write is acknowledged.
//   Also tracks load completion and generates the core's active-low reset
//   with a post-load hold period.
//
// Ports:
//   clk_sys          system clock (48 MHz domain)
//   reset            asynchronous active-low reset
//   bus              download stream + two SDRAM write ports (master side)
//   user_reset       OSD/button reset request, active-high
//   rom_loaded       sticky, set at the end of the first download
//   core_reset_n     core reset, active-low
//   ack_timeout_err  sticky, an acknowledge never arrived
//   overrun_err      sticky, a byte strobe arrived while a write was busy
// ---------------------------------------------------------------------------
module rom_download_sequencer #(
    parameter logic [24:0] BG_BASE     = 25'h00C000,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255,
    parameter logic [15:0] RESET_HOLD  = 16'd1024
) (
    input  logic                            clk_sys,
    input  logic                            reset,
    rom_download_sequencer_if.master        bus,
    input  logic                            user_reset,
    output logic                            rom_loaded,
    output logic                            core_reset_n,
    output logic                            ack_timeout_err,
    output logic                            overrun_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Byte-lane select for a 16-bit word: high lane when the select bit is set.
    function automatic logic [1:0] lane_select(input logic hi);
        return {hi, ~hi};
    endfunction

    // A byte is written to both lanes; ds picks the one that lands.
    function automatic logic [15:0] lane_data(input logic [7:0] b);
        return {b, b};
    endfunction

    logic        wr_d_r;
    logic        downl_d_r;
    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        wait_r;

    logic [22:0] p1_a_lat_r;
    logic        p1_hi_lat_r;
    logic [22:0] p2_a_lat_r;
    logic        p2_hi_lat_r;
    logic [7:0]  byte_lat_r;
    logic        need2_r;

    logic        port1_req_r;
    logic [22:0] port1_a_r;
    logic [1:0]  port1_ds_r;
    logic [15:0] port1_d_r;
    logic        port2_req_r;
    logic [22:0] port2_a_r;
    logic [1:0]  port2_ds_r;
    logic [15:0] port2_d_r;
    logic        we_r;

    logic [7:0]  tmo_cnt_r;
    logic        ack_timeout_err_r;
    logic        overrun_err_r;
    logic        end_pend_r;
    logic        rom_loaded_r;
    logic [15:0] hold_cnt_r;
    logic        core_reset_n_r;

    logic        edge_s;
    logic        fall_s;
    logic        done_s;
    logic        timeout_s;
    logic        cause_s;
    logic [23:0] bg_s;

    // Only the low 24 bits of the rebased address are ever used, so the
    // subtraction wraps freely; bit 24 only matters for the BG_BASE compare.
    assign bg_s      = bus.ioctl_addr[23:0] - BG_BASE[23:0];
    assign edge_s    = bus.ioctl_wr & ~wr_d_r & bus.ioctl_downl;
    assign fall_s    = ~bus.ioctl_downl & downl_d_r;
    assign done_s    = (bus.port1_ack == port1_req_r) &&
                       (~need2_r || (bus.port2_ack == port2_req_r));
    assign timeout_s = (tmo_cnt_r == ACK_TIMEOUT);
    assign cause_s   = ~rom_loaded_r | bus.ioctl_downl | user_reset;

    // Next-state logic of the write sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_s || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, byte latch, port request generation and error flags.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            wr_d_r            <= 1'b0;
            downl_d_r         <= 1'b0;
            state_r           <= ST_IDLE;
            wait_r            <= 1'b0;
            p1_a_lat_r        <= 23'd0;
            p1_hi_lat_r       <= 1'b0;
            p2_a_lat_r        <= 23'd0;
            p2_hi_lat_r       <= 1'b0;
            byte_lat_r        <= 8'd0;
            need2_r           <= 1'b0;
            port1_req_r       <= 1'b0;
            port1_a_r         <= 23'd0;
            port1_ds_r        <= 2'd0;
            port1_d_r         <= 16'd0;
            port2_req_r       <= 1'b0;
            port2_a_r         <= 23'd0;
            port2_ds_r        <= 2'd0;
            port2_d_r         <= 16'd0;
            we_r              <= 1'b0;
            tmo_cnt_r         <= 8'd0;
            ack_timeout_err_r <= 1'b0;
            overrun_err_r     <= 1'b0;
        end else begin
            wr_d_r    <= bus.ioctl_wr;
            downl_d_r <= bus.ioctl_downl;
            state_r   <= state_nxt_s;
            // Registered form of (state != IDLE): same timing as decoding
            // the state combinationally.
            wait_r    <= (state_nxt_s != ST_IDLE);
            we_r      <= bus.ioctl_downl;

            if ((state_r == ST_IDLE) && edge_s) begin
                p1_a_lat_r  <= bus.ioctl_addr[23:1];
                p1_hi_lat_r <= bus.ioctl_addr[0];
                p2_a_lat_r  <= {bg_s[23:14], bg_s[12:0]};
                p2_hi_lat_r <= bg_s[13];
                byte_lat_r  <= bus.ioctl_dout;
                need2_r     <= (bus.ioctl_addr >= BG_BASE);
            end else begin
                p1_a_lat_r  <= p1_a_lat_r;
                p1_hi_lat_r <= p1_hi_lat_r;
                p2_a_lat_r  <= p2_a_lat_r;
                p2_hi_lat_r <= p2_hi_lat_r;
                byte_lat_r  <= byte_lat_r;
                need2_r     <= need2_r;
            end

            // Strobes that arrive while a write is in flight are discarded.
            if (edge_s && (state_r != ST_IDLE)) begin
                overrun_err_r <= 1'b1;
            end else begin
                overrun_err_r <= overrun_err_r;
            end

            if (state_r == ST_ISSUE) begin
                port1_a_r   <= p1_a_lat_r;
                port1_ds_r  <= lane_select(p1_hi_lat_r);
                port1_d_r   <= lane_data(byte_lat_r);
                port1_req_r <= ~port1_req_r;
                // port2 keeps the previous graphics write when not targeted.
                if (need2_r) begin
                    port2_a_r   <= p2_a_lat_r;
                    port2_ds_r  <= lane_select(p2_hi_lat_r);
                    port2_d_r   <= lane_data(byte_lat_r);
                    port2_req_r <= ~port2_req_r;
                end else begin
                    port2_a_r   <= port2_a_r;
                    port2_ds_r  <= port2_ds_r;
                    port2_d_r   <= port2_d_r;
                    port2_req_r <= port2_req_r;
                end
                tmo_cnt_r <= 8'd0;
            end else if ((state_r == ST_WAIT) && !done_s && !timeout_s) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end

            // A timed-out write is abandoned without re-toggling; the
            // request parity simply stays where it is.
            if ((state_r == ST_WAIT) && !done_s && timeout_s) begin
                ack_timeout_err_r <= 1'b1;
            end else begin
                ack_timeout_err_r <= ack_timeout_err_r;
            end
        end
    end

    // Load-complete flag: a download end seen while a write is still in
    // flight is remembered until the sequencer returns to IDLE.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            end_pend_r   <= 1'b0;
            rom_loaded_r <= 1'b0;
        end else if ((fall_s || end_pend_r) && (state_nxt_s == ST_IDLE)) begin
            end_pend_r   <= 1'b0;
            rom_loaded_r <= 1'b1;
        end else if (fall_s) begin
            end_pend_r   <= 1'b1;
            rom_loaded_r <= rom_loaded_r;
        end else begin
            end_pend_r   <= end_pend_r;
            rom_loaded_r <= rom_loaded_r;
        end
    end

    // Core reset: held while any cause is present, then released after the
    // hold counter has run down to zero.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            hold_cnt_r     <= RESET_HOLD;
            core_reset_n_r <= 1'b0;
        end else if (cause_s) begin
            hold_cnt_r     <= RESET_HOLD;
            core_reset_n_r <= 1'b0;
        end else if (hold_cnt_r != 16'd0) begin
            hold_cnt_r     <= hold_cnt_r - 16'd1;
            core_reset_n_r <= 1'b0;
        end else begin
            hold_cnt_r     <= hold_cnt_r;
            core_reset_n_r <= 1'b1;
        end
    end

    assign bus.ioctl_wait = wait_r;
    assign bus.port1_req  = port1_req_r;
    assign bus.port1_a    = port1_a_r;
    assign bus.port1_ds   = port1_ds_r;
    assign bus.port1_d    = port1_d_r;
    assign bus.port1_we   = we_r;
    assign bus.port2_req  = port2_req_r;
    assign bus.port2_a    = port2_a_r;
    assign bus.port2_ds   = port2_ds_r;
    assign bus.port2_d    = port2_d_r;
    assign bus.port2_we   = we_r;

    assign rom_loaded      = rom_loaded_r;
    assign core_reset_n    = core_reset_n_r;
    assign ack_timeout_err = ack_timeout_err_r;
    assign overrun_err     = overrun_err_r;

endmodule

// File: doc/rom_download_sequencer.md
Name: rom_download_sequencer

Overview:
- Sequences ROM bytes from data_io into SDRAM over the two toggle-handshake write ports, port1 (CPU image) and port2 (merged background/sprite graphics).
- Holds data_io off with a wait signal until every issued write is acknowledged.
- Tracks load completion and drives the core's active-low reset, including a post-load hold period.
- Sits between data_io, the sdram controller and the game core in the top level.

Parameters:
- BG_BASE, 25'h00C000, first download address routed additionally to port2.
- ACK_TIMEOUT, 8'd255, max cycles to wait for an ack before giving up.
- RESET_HOLD, 16'd1024, cycles core_reset_n stays low after reset causes clear.

Ports:
- clk_sys  in  1  system clock (48 MHz domain)
- reset  in  1  asynchronous, active-low reset
- ioctl_downl  in  1  download active
- ioctl_wr  in  1  byte strobe (level; rising edge = new byte)
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  high while a byte is in flight
- port1_req  out  1  toggle request, port1
- port1_ack  in  1  toggle ack, port1
- port1_a  out  23  word address = addr[23:1]
- port1_ds  out  2  {addr[0], ~addr[0]}
- port1_d  out  16  {byte, byte}
- port1_we  out  1  write enable
- port2_req  out  1  toggle request, port2
- port2_ack  in  1  toggle ack, port2
- port2_a  out  23  {bg[23:14], bg[12:0]}, where bg = addr - BG_BASE
- port2_ds  out  2  {bg[13], ~bg[13]}
- port2_d  out  16  {byte, byte}
- port2_we  out  1  write enable
- user_reset  in  1  OSD/button reset request, active-high
- rom_loaded  out  1  sticky, set at end of first download
- core_reset_n  out  1  core reset, active-low
- ack_timeout_err  out  1  sticky, an ack timed out
- overrun_err  out  1  sticky, a strobe arrived while busy

Behaviour:
- Reset (reset low, asynchronous) forces all outputs to these values:
  - port*_req=0, port*_we=0, port*_a=0, port*_ds=0, port*_d=0;
  - ioctl_wait=0, rom_loaded=0, core_reset_n=0, both error flags=0;
  - FSM=IDLE, timeout counter=0, hold counter=RESET_HOLD.
  - Asserting reset mid-transfer abandons the transfer; the sdram controller shares the reset, so req/ack parity realigns at 0.
- ioctl_wr is registered once. Edge = ioctl_wr & ~ioctl_wr_d, qualified by ioctl_downl.
- FSM:
  - IDLE: on edge, latch addr and byte. Compute bg = addr - BG_BASE (25-bit, wrap ignored). Set need2 = (addr >= BG_BASE). Go to ISSUE.
  - ISSUE (1 cycle): drive port fields from the latch. Toggle port1_req. Toggle port2_req only if need2. Clear the timeout counter. Go to WAIT.
  - WAIT: done when port1_ack==port1_req and (~need2 or port2_ack==port2_req). Done -> IDLE. If the counter reaches ACK_TIMEOUT first, set ack_timeout_err and go to IDLE without re-toggling.
- ioctl_wait = (state != IDLE). It rises the cycle after the edge is detected and falls the cycle after WAIT exits. Minimum byte latency: edge + 3 cycles.
- Edge detected while not IDLE: the byte is dropped and overrun_err is set. The FSM is unaffected.
- port*_we = ioctl_downl registered.
- port*_a/ds/d hold their values between requests and change only in ISSUE.
- Download end (ioctl_downl falling edge):
  - Sets rom_loaded once the FSM is in IDLE. If WAIT is in progress, rom_loaded sets the cycle WAIT exits.
  - rom_loaded never clears except on reset.
- core_reset_n:
  - Cause = ~rom_loaded | ioctl_downl | user_reset.
  - While cause is present, core_reset_n=0 and the hold counter is reloaded to RESET_HOLD.
  - After cause clears, the counter decrements each cycle; core_reset_n goes 1 the cycle after the counter reaches 0.
  - A new cause during the countdown reloads the counter.
- A new download after rom_loaded re-asserts core_reset_n low via ioctl_downl and streams normally.

Test Plan:
- Write 0x5A at addr 0x0003 with the ack echoing 2 cycles after req -> port1_a=1, ds=2'b10, d=16'h5A5A, port1_req toggles once, port2_req unchanged, ioctl_wait high for 4 cycles.
- Write at addr 0xE005 -> port2_a=23'h000005, ds=2'b10 (bg=0x2005, bit13=1), port2_req and port1_req both toggle, ioctl_wait releases only after both acks.
- Hold port2_ack fixed on a BG write -> ack_timeout_err=1 after 255 WAIT cycles, FSM returns to IDLE, and the next byte proceeds normally.
- Pulse ioctl_wr twice, 1 cycle apart, while the first byte is still in WAIT -> second byte dropped, overrun_err=1, exactly one port1_req toggle.
- Download ends, then user_reset pulses 1 cycle at count 500 of the hold -> rom_loaded=1; core_reset_n rises 1025 cycles after the pulse.
- Assert reset low mid-WAIT -> all outputs return to reset values immediately; rom_loaded=0, core_reset_n=0.
